hazard_control_r0: RTL
======================

# hazard_control_r0

Pipeline hazard and stall controller for the five-stage MIPS datapath. It detects load-use hazards and the hazards caused by branches and jr resolving operands in ID. It then sequences multi-cycle stalls: it holds PC and IF/ID and injects bubbles into ID/EX. It also freezes the whole pipeline on an external wait request. It sits beside the data forwarding unit and drives the `en_n` inputs of the pipeline `delay` registers and the ID/EX flush.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, width of stall performance counter
- STALL_WIDTH, 2, width of internal remaining-stall counter
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction (0 when ID is flushed)
- id_rs, id_rt  in  REG_ADDR_WIDTH  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_branch  in  1  ID instruction is beq/bne/jr (operands consumed in ID)
- ex_memRead, ex_regWrite  in  1  EX-stage control
- ex_regToWrite  in  REG_ADDR_WIDTH  EX destination
- mem_memRead  in  1  MEM-stage load
- mem_regToWrite  in  REG_ADDR_WIDTH  MEM destination
- ext_stall_req  in  1  level request to freeze the entire pipeline (memory wait, debug)
- pc_en_n  out  1  1 = hold PC
- ifid_en_n  out  1  1 = hold IF/ID registers
- idex_flush  out  1  1 = load zero control (bubble) into ID/EX
- pipe_en_n  out  1  1 = hold ID/EX, EX/MEM, MEM/WB
- busy  out  1  FSM not in RUN
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_en_n=1

## Operation
- Match rule: a source matches a destination when the source is used, the addresses are equal, and the destination is nonzero. $0 never matches. No hazard when id_valid=0.
- Required stall count n is the maximum of the following:
  - non-branch consumer, ex_memRead match: 1
  - branch consumer, ex_regWrite & !ex_memRead match: 1
  - branch consumer, ex_memRead match: 2
  - branch consumer, mem_memRead match: 1
  - otherwise: 0
- FSM states: RUN, HAZ, EXT. `cnt` holds the remaining stalls; `ret` holds the return state for EXT.
- RUN:
  - ext_stall_req=1: assert pc_en_n, ifid_en_n, pipe_en_n; ret<=RUN; go EXT.
  - Otherwise, n>0: assert pc_en_n, ifid_en_n, idex_flush this cycle.
    - n=1: stay RUN.
    - n=2: cnt<=1, go HAZ.
  - Otherwise: all outputs 0.
- HAZ: hazards are not re-evaluated.
  - ext_stall_req=1: freeze as in EXT; ret<=HAZ; cnt unchanged; go EXT.
  - Otherwise: assert pc_en_n, ifid_en_n, idex_flush; cnt<=cnt-1; when cnt=1, go RUN.
- EXT: pc_en_n=ifid_en_n=pipe_en_n=1, idex_flush=0. When ext_stall_req=0, the cycle is a normal cycle of state `ret` (outputs evaluated as in that state), and the FSM advances from it.
- Priority: ext_stall_req over hazard. idex_flush and pipe_en_n are never both 1.
- stall_cycles increments every cycle pc_en_n=1 and saturates at all-ones.

## Timing
- Outputs are Mealy: combinational from state and inputs. Zero-cycle latency from hazard detection to stall assertion.
- State, cnt, ret and stall_cycles update on the rising clk edge.
- Load-use: exactly 1 bubble.
- Branch-on-load in EX: exactly 2 bubbles, in consecutive cycles (RUN cycle plus 1 HAZ cycle).
- EXT inserted mid-HAZ extends the stall by the EXT duration; the total bubble count is unchanged.
- Reset: while rst=0 at a clock edge, state<=RUN, cnt<=0, ret<=RUN, stall_cycles<=0. Outputs are 0 in the first cycle after reset unless inputs create a hazard.
- Reset asserted mid-HAZ or mid-EXT aborts the stall immediately at that edge.

## Structure
- Shared package `mips_pipe_pkg`:
  - state enum {RUN, HAZ, EXT}
  - constants LOAD_USE_STALLS=1, BRANCH_ALU_STALLS=1, BRANCH_LOAD_STALLS=2
- Sub-module `hazard_detect_r0`: purely combinational match and n computation. The FSM, counters and output decode stay in `hazard_control_r0`.

## Test plan
- Load-use: EX lw $5, ID add uses rs=$5 → one cycle of pc_en_n=ifid_en_n=idex_flush=1, then 0; stall_cycles=1.
- Branch on ALU result: EX add → $3 (ex_regWrite=1), ID beq rs=$3 → 1 stall. Same case with rd=$0 → no stall.
- Branch on load: EX lw $7, ID bne rt=$7 → stall 2 consecutive cycles, busy=1 in the second cycle; then RUN, stall_cycles=2.
- External wait mid-HAZ: in the HAZ cycle, raise ext_stall_req for 3 cycles → pipe_en_n=1 and idex_flush=0 for 3 cycles, then 1 HAZ cycle with idex_flush=1, then RUN.
- id_valid=0 with matching load in EX → no stall. Reset (rst=0) asserted during EXT → next cycle state RUN, all outputs 0, stall_cycles=0.
- Counter saturation with CNT_WIDTH=4: 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and stall constants
// for the five-stage MIPS datapath.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    EXT = 2'd2
  } state_t;

  localparam int LOAD_USE_STALLS    = 1;
  localparam int BRANCH_ALU_STALLS  = 1;
  localparam int BRANCH_LOAD_STALLS = 2;

endpackage

// File: rtl/hazard_detect_r0.sv
// Combinational hazard match and required
// stall count for the instruction in ID.
module hazard_detect_r0
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STALL_WIDTH    = 2
) (
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_branch,
  input  logic                      ex_memRead,
  input  logic                      ex_regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
  input  logic                      mem_memRead,
  input  logic [REG_ADDR_WIDTH-1:0] mem_regToWrite,
  output logic [STALL_WIDTH-1:0]    n
);

  localparam logic [STALL_WIDTH-1:0] N_LU =
    STALL_WIDTH'(LOAD_USE_STALLS);
  localparam logic [STALL_WIDTH-1:0] N_BA =
    STALL_WIDTH'(BRANCH_ALU_STALLS);
  localparam logic [STALL_WIDTH-1:0] N_BL =
    STALL_WIDTH'(BRANCH_LOAD_STALLS);

  logic ex_m;
  logic mem_m;
  logic [STALL_WIDTH-1:0] c_lu;
  logic [STALL_WIDTH-1:0] c_ba;
  logic [STALL_WIDTH-1:0] c_bl;
  logic [STALL_WIDTH-1:0] c_bm;
  logic [STALL_WIDTH-1:0] m0;
  logic [STALL_WIDTH-1:0] m1;

  // $0 is hardwired, so it never carries a hazard
  assign ex_m = id_valid && (ex_regToWrite != '0) &&
    ((id_uses_rs && id_rs == ex_regToWrite) ||
     (id_uses_rt && id_rt == ex_regToWrite));

  assign mem_m = id_valid && (mem_regToWrite != '0) &&
    ((id_uses_rs && id_rs == mem_regToWrite) ||
     (id_uses_rt && id_rt == mem_regToWrite));

  assign c_lu = (!id_branch && ex_memRead && ex_m)
    ? N_LU : '0;
  assign c_ba = (id_branch && ex_regWrite &&
    !ex_memRead && ex_m) ? N_BA : '0;
  assign c_bl = (id_branch && ex_memRead && ex_m)
    ? N_BL : '0;
  assign c_bm = (id_branch && mem_memRead && mem_m)
    ? N_BA : '0;

  assign m0 = (c_lu > c_ba) ? c_lu : c_ba;
  assign m1 = (c_bl > c_bm) ? c_bl : c_bm;
  assign n  = (m0 > m1) ? m0 : m1;

endmodule

// File: rtl/hazard_control_r0.sv
// Stall sequencer: bubbles on hazards, freezes
// the pipeline on external wait requests.
module hazard_control_r0
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int STALL_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_branch,
  input  logic                      ex_memRead,
  input  logic                      ex_regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
  input  logic                      mem_memRead,
  input  logic [REG_ADDR_WIDTH-1:0] mem_regToWrite,
  input  logic                      ext_stall_req,
  output logic                      pc_en_n,
  output logic                      ifid_en_n,
  output logic                      idex_flush,
  output logic                      pipe_en_n,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  state_t state;
  state_t state_nx;
  state_t ret;
  state_t ret_nx;
  state_t cur;
  logic [STALL_WIDTH-1:0] cnt;
  logic [STALL_WIDTH-1:0] cnt_nx;
  logic [STALL_WIDTH-1:0] n;

  hazard_detect_r0 #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .STALL_WIDTH   (STALL_WIDTH)
  ) u_detect (
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_branch     (id_branch),
    .ex_memRead    (ex_memRead),
    .ex_regWrite   (ex_regWrite),
    .ex_regToWrite (ex_regToWrite),
    .mem_memRead   (mem_memRead),
    .mem_regToWrite(mem_regToWrite),
    .n             (n)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      ret   <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      cnt   <= cnt_nx;
    end
  end

  // Leaving EXT behaves as a normal cycle of the saved state
  assign cur = (state == EXT) ? ret : state;

  always_comb begin
    state_nx   = cur;
    ret_nx     = ret;
    cnt_nx     = cnt;
    pc_en_n    = 1'b0;
    ifid_en_n  = 1'b0;
    idex_flush = 1'b0;
    pipe_en_n  = 1'b0;
    if (ext_stall_req) begin
      pc_en_n   = 1'b1;
      ifid_en_n = 1'b1;
      pipe_en_n = 1'b1;
      ret_nx    = cur;
      state_nx  = EXT;
    end else begin
      unique case (cur)
        HAZ: begin
          pc_en_n    = 1'b1;
          ifid_en_n  = 1'b1;
          idex_flush = 1'b1;
          cnt_nx     = cnt - 1'b1;
          state_nx   = (cnt == STALL_WIDTH'(1))
            ? RUN : HAZ;
        end
        default: begin
          state_nx = RUN;
          if (n != '0) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            idex_flush = 1'b1;
            if (n > STALL_WIDTH'(1)) begin
              cnt_nx   = n - 1'b1;
              state_nx = HAZ;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state != RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (pc_en_n && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
